// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared definitions for the EX-stage divide sequencer
// State encodings, ALU/function codes for DIV/DIVU and the default operand width.
package div_ctrl_pkg;

  localparam int def_width = 32;

  typedef enum logic [1:0] {
    div_idle    = 2'b00,
    div_by_zero = 2'b01,
    div_on      = 2'b10,
    div_end     = 2'b11
  } div_state_t;

  localparam logic [7:0] aluop_div  = 8'b0001_1010;
  localparam logic [7:0] aluop_divu = 8'b0001_1011;

  localparam logic [5:0] func_div   = 6'b01_1010;
  localparam logic [5:0] func_divu  = 6'b01_1011;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
// Shifts in the next dividend bit and subtracts the divisor when it fits.
module div_step
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = def_width
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted  = {rem, dvd_bit};
  assign diff     = shifted - {1'b0, divisor};
  // rem < divisor keeps shifted below 2*divisor, so the top bit of diff is a clean borrow
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle DIV/DIVU sequencer with pipeline stall request
// Optional build macro DIV_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = def_width,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             annul,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             ready,
  output logic             stall_req,
  output logic             busy
);

  div_state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q, dvd_q, dsr_q;
  logic             neg_quo, neg_rem;

  logic [WIDTH-1:0] dvd_mag, dsr_mag, rem_next, quo_final;
  logic             q_bit, div_zero, early, last_step;

  assign dvd_mag   = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dsr_mag   = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign div_zero  = (divisor == '0);
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
  assign quo_final = {dvd_q[WIDTH-2:0], q_bit};

`ifdef DIV_EARLY_OUT_EN
  assign early = (dvd_mag < dsr_mag);
`else
  assign early = 1'b0;
`endif

  // dvd_q doubles as the quotient shift register: dividend bits leave the top, quotient bits enter the bottom
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd_bit  (dvd_q[WIDTH-1]),
    .divisor  (dsr_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= div_idle;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (annul) begin
      state_next = div_idle;
    end else begin
      case (state)
        div_idle:    if (start) state_next = div_zero ? div_by_zero : (early ? div_end : div_on);
        div_by_zero: state_next = div_end;
        div_on:      if (last_step) state_next = div_end;
        div_end:     state_next = div_idle;
        default:     state_next = div_idle;
      endcase
    end
  end

  always_comb begin
    busy      = (state != div_idle);
    ready     = (state == div_end) && !annul;
    stall_req = 1'b0;
    case (state)
      div_idle:    stall_req = start && !annul && !rst;
      div_by_zero: stall_req = 1'b1;
      div_on:      stall_req = 1'b1;
      default:     stall_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      case (state)
        div_idle: if (start && !annul) begin
          cnt     <= '0;
          rem_q   <= '0;
          dsr_q   <= dsr_mag;
          dvd_q   <= div_zero ? dividend : dvd_mag;
          neg_quo <= signed_div && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem <= signed_div && dividend[WIDTH-1];
          if (!div_zero && early) begin
            result_lo <= '0;
            result_hi <= dividend;
          end
        end
        div_by_zero: if (!annul) begin
          result_lo <= '1;
          result_hi <= dvd_q;
        end
        div_on: if (!annul) begin
          cnt   <= cnt + 1'b1;
          rem_q <= rem_next;
          dvd_q <= quo_final;
          if (last_step) begin
            result_lo <= neg_quo ? -quo_final : quo_final;
            result_hi <= neg_rem ? -rem_next  : rem_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
